pipelined_adder_nbit: RTL
=========================

# pipelined_adder_nbit

Parametrised, pipelined n-bit adder with carry-in, unsigned carry-out and signed overflow, and a valid/ready stream handshake on both sides. The carry chain is split into equal chunks, one chunk per pipeline stage, so wide adds close timing at one result per clock. It is the clocked, scalable successor to the 4-bit combinational adder. It sits between operand producers and any datapath consumer that can apply backpressure.

## Interface
- NUM_BITS, 16, operand and sum width; must be ≥ 2.
- NUM_STAGES, 4, pipeline depth; must divide NUM_BITS. Chunk width CW = NUM_BITS / NUM_STAGES.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- a  input  NUM_BITS  operand A.
- b  input  NUM_BITS  operand B.
- carry_in  input  1  carry into bit 0.
- in_valid  input  1  a/b/carry_in hold a transaction.
- in_ready  output  1  block accepts this cycle.
- sum  output  NUM_BITS  (a + b + carry_in) mod 2^NUM_BITS.
- carry_out  output  1  carry out of bit NUM_BITS-1 (unsigned overflow).
- overflow  output  1  two's-complement overflow = carry into MSB XOR carry_out.
- out_valid  output  1  sum/carry_out/overflow hold a result.
- out_ready  input  1  consumer accepts the result this cycle.

## Operation
- Stage k (0..NUM_STAGES-1) adds operand bits [k·CW +: CW] plus the carry registered by stage k-1. Stage 0 uses carry_in.
- Each stage register holds: valid bit, chunk carry, the completed lower sum bits, the not-yet-summed upper a/b bits, and the carry into the MSB once the last chunk is summed.
- Last stage drives sum, carry_out, overflow and out_valid directly from registers. No combinational path from a/b to outputs.
- Advance: adv = !out_valid || out_ready. When adv = 1, all stages shift one step together. When adv = 0, all stages hold.
- in_ready = adv (combinational). A transfer occurs on a rising edge with in_valid && in_ready. With in_valid = 0 and adv = 1, a bubble (valid = 0) enters stage 0.
- Bubbles are not collapsed. Transaction order is preserved exactly.
- Output transfer occurs on an edge with out_valid && out_ready. sum/carry_out/overflow stay stable while out_valid = 1 && out_ready = 0.
- Arithmetic is exact for all 2^(2·NUM_BITS+1) input combinations. NUM_STAGES = 1 degenerates to a registered full adder.

## Timing
- Reset (rst = 1 at an edge): all valid bits, data, and carry registers are cleared to 0. After reset: sum = 0, carry_out = 0, overflow = 0, out_valid = 0. in_ready = 1 in the cycle after reset.
- Reset mid-operation: every in-flight transaction is discarded and never appears at the outputs. Reset overrides a simultaneous input transfer.
- Latency: a transaction accepted at edge N is presented with out_valid = 1 after edge N + NUM_STAGES - 1, so it is visible NUM_STAGES cycles after acceptance, provided adv stayed 1 throughout. Each stall cycle adds exactly one cycle.
- Throughput: one transaction per cycle while out_ready = 1.
- Simultaneous output pop and input accept: both occur on the same edge with no lost cycle.
- Full stall: out_valid = 1 && out_ready = 0 forces in_ready = 0. Up to NUM_STAGES transactions remain held without loss.

## Test plan
- Carry ripple (16/4): a = 0xFFFF, b = 0x0001, cin = 0, out_ready = 1 -> after 4 cycles sum = 0x0000, carry_out = 1, overflow = 0, out_valid high for 1 cycle.
- Signed overflow (16/4): a = 0x7FFF, b = 0x0001, cin = 0 -> sum = 0x8000, carry_out = 0, overflow = 1. Then a = 0x8000, b = 0x8000, cin = 1 -> sum = 0x0001, carry_out = 1, overflow = 1.
- Streaming: 4 back-to-back inputs (1+2, 3+4, 5+6, 7+8) with cin = 0 -> sums 3, 7, 11, 15 appear on 4 consecutive cycles, in order, with no gaps.
- Backpressure: stream 6 transactions and drop out_ready for 3 cycles while out_valid = 1 -> in_ready = 0 during the stall, outputs held stable, all 6 results delivered in order, none duplicated.
- Reset mid-flight: accept 2 transactions, assert rst one cycle later -> out_valid stays 0, all outputs read 0, and a new transaction after reset completes with the correct latency.
- Exhaustive (NUM_BITS = 4, NUM_STAGES = 2, NUM_BITS = 16 with NUM_STAGES = 1): all 512 combinations of a, b, cin for the 4-bit build, plus a random sweep for the 16-bit build -> sum, carry_out and overflow match a + b + cin, and latency equals NUM_STAGES.

Source files
------------

// File: rtl/pipelined_adder_nbit.sv
// rtl/pipelined_adder_nbit.sv - pipelined n-bit adder, one carry chunk per stage, valid/ready on both sides
module pipelined_adder_nbit #(
  parameter int NUM_BITS   = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out,
  output logic                overflow,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CW = NUM_BITS / NUM_STAGES;

  typedef struct packed {
    logic                carry;
    logic                msb_carry;
    logic [NUM_BITS-1:0] sum;
  } step_t;

  logic                valid_q [NUM_STAGES];
  logic                valid_d [NUM_STAGES];
  logic                carry_q [NUM_STAGES];
  logic                carry_d [NUM_STAGES];
  logic                msb_q   [NUM_STAGES];
  logic                msb_d   [NUM_STAGES];
  logic [NUM_BITS-1:0] sum_q   [NUM_STAGES];
  logic [NUM_BITS-1:0] sum_d   [NUM_STAGES];
  logic [NUM_BITS-1:0] a_q     [NUM_STAGES];
  logic [NUM_BITS-1:0] a_d     [NUM_STAGES];
  logic [NUM_BITS-1:0] b_q     [NUM_STAGES];
  logic [NUM_BITS-1:0] b_d     [NUM_STAGES];

  logic                adv;
  logic [NUM_BITS-1:0] a_in;
  logic [NUM_BITS-1:0] b_in;
  step_t               step;

  // Adds chunk k into the running sum; msb_carry is the carry into the chunk's top bit,
  // which equals the carry into the word MSB once k is the last chunk.
  function automatic step_t chunk_add(input int k, input logic [NUM_BITS-1:0] av,
                                      input logic [NUM_BITS-1:0] bv,
                                      input logic [NUM_BITS-1:0] sv, input logic cv);
    step_t      r;
    logic [CW:0] ext;
    ext = {1'b0, av[k*CW +: CW]} + {1'b0, bv[k*CW +: CW]} + {{CW{1'b0}}, cv};
    r.sum = sv;
    r.sum[k*CW +: CW] = ext[CW-1:0];
    r.carry = ext[CW];
    r.msb_carry = av[k*CW + CW - 1] ^ bv[k*CW + CW - 1] ^ ext[CW-1];
    return r;
  endfunction

  always_comb begin
    adv  = !valid_q[NUM_STAGES-1] || out_ready;
    // Bubbles carry zero data so idle outputs stay at zero.
    a_in = in_valid ? a : '0;
    b_in = in_valid ? b : '0;
    step = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      valid_d[k] = valid_q[k];
      carry_d[k] = carry_q[k];
      msb_d[k]   = msb_q[k];
      sum_d[k]   = sum_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
    end
    if (adv) begin
      step       = chunk_add(0, a_in, b_in, '0, in_valid & carry_in);
      valid_d[0] = in_valid;
      carry_d[0] = step.carry;
      msb_d[0]   = step.msb_carry;
      sum_d[0]   = step.sum;
      a_d[0]     = a_in;
      b_d[0]     = b_in;
      for (int k = 1; k < NUM_STAGES; k++) begin
        step       = chunk_add(k, a_q[k-1], b_q[k-1], sum_q[k-1], carry_q[k-1]);
        valid_d[k] = valid_q[k-1];
        carry_d[k] = step.carry;
        msb_d[k]   = step.msb_carry;
        sum_d[k]   = step.sum;
        a_d[k]     = a_q[k-1];
        b_d[k]     = b_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        msb_q[k]   <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        msb_q[k]   <= msb_d[k];
        sum_q[k]   <= sum_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = valid_q[NUM_STAGES-1];
  assign sum       = sum_q[NUM_STAGES-1];
  assign carry_out = carry_q[NUM_STAGES-1];
  assign overflow  = msb_q[NUM_STAGES-1] ^ carry_q[NUM_STAGES-1];

endmodule
